// File: rtl/ram_mfc_responder.sv
// Memory-side responder for the MFA/MFC handshake: byte-addressed, big-endian storage
// with a fixed access latency, serving fetch and LDR/STR datapaths.
module ram_mfc_responder #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        MFA,
    input  logic        RW_RAM,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] DATA_IN,
    input  logic [1:0]  TYPE,
    output logic [31:0] DATA_OUT,
    output logic        MFC
);

    localparam int unsigned Words   = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [1:0]              type_q, type_d;
    logic                    mfc_q, mfc_d;
    logic [31:0]             dout_q, dout_d;

    // Storage is word-organised; byte lane 3 (bits 31:24) holds the lowest byte address.
    logic [31:0]             mem [Words];
    logic [ADDR_WIDTH-3:0]   word_idx;
    logic [31:0]             rd_word;
    logic [31:0]             rd_data;
    logic [31:0]             wr_data;
    logic [3:0]              wr_be;
    logic                    mem_we;

    logic                    unused_addr_hi;
    assign unused_addr_hi = ^ADDRESS[31:ADDR_WIDTH];

    assign word_idx = addr_q[ADDR_WIDTH-1:2];
    assign rd_word  = mem[word_idx];

    always_comb begin
        rd_data = 32'h0;
        case (type_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0:    rd_data[7:0] = rd_word[31:24];
                    2'd1:    rd_data[7:0] = rd_word[23:16];
                    2'd2:    rd_data[7:0] = rd_word[15:8];
                    default: rd_data[7:0] = rd_word[7:0];
                endcase
            end
            2'b01:   rd_data[15:0] = addr_q[1] ? rd_word[15:0] : rd_word[31:16];
            default: rd_data = rd_word;
        endcase
    end

    always_comb begin
        wr_data = wdata_q;
        wr_be   = 4'b0000;
        case (type_q)
            2'b00: begin
                wr_data = {4{wdata_q[7:0]}};
                case (addr_q[1:0])
                    2'd0:    wr_be = 4'b1000;
                    2'd1:    wr_be = 4'b0100;
                    2'd2:    wr_be = 4'b0010;
                    default: wr_be = 4'b0001;
                endcase
            end
            2'b01: begin
                wr_data = {2{wdata_q[15:0]}};
                wr_be   = addr_q[1] ? 4'b0011 : 4'b1100;
            end
            default: wr_be = 4'b1111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        type_d  = type_q;
        mfc_d   = mfc_q;
        dout_d  = dout_q;
        mem_we  = 1'b0;
        case (state_q)
            StIdle: begin
                if (MFA) begin
                    rw_d    = RW_RAM;
                    addr_d  = ADDRESS[ADDR_WIDTH-1:0];
                    wdata_d = DATA_IN;
                    type_d  = TYPE;
                    cnt_d   = CntInit;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!MFA) begin
                    state_d = StIdle;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mfc_d   = 1'b1;
                    state_d = StDone;
                    if (rw_q) begin
                        dout_d = rd_data;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
            StDone: begin
                if (!MFA) begin
                    mfc_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Reset drops any in-flight write.
        if (CLR) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            type_q  <= 2'b00;
            mfc_q   <= 1'b0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            type_q  <= type_d;
            mfc_q   <= mfc_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign DATA_OUT = dout_q;
    assign MFC      = mfc_q;

endmodule

// File: tb/tb_ram_mfc_responder.sv
// Directed bench for ram_mfc_responder: handshake timing, big-endian access, abort,
// hold/release, reset mid-operation and address wrap.
module tb_ram_mfc_responder;

    localparam int Lat = 2;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        MFA;
    logic        RW_RAM;
    logic [31:0] ADDRESS;
    logic [31:0] DATA_IN;
    logic [1:0]  TYPE;
    logic [31:0] DATA_OUT;
    logic        MFC;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_dout;

    ram_mfc_responder #(
        .ADDR_WIDTH (9),
        .LATENCY    (Lat)
    ) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .MFA      (MFA),
        .RW_RAM   (RW_RAM),
        .ADDRESS  (ADDRESS),
        .DATA_IN  (DATA_IN),
        .TYPE     (TYPE),
        .DATA_OUT (DATA_OUT),
        .MFC      (MFC)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called and returns at a negedge; inputs are scrambled after acceptance.
    task automatic access(input string tag, input logic rw, input logic [31:0] addr,
                          input logic [31:0] din, input logic [1:0] typ,
                          input logic [31:0] exp_dout, input int hold);
        MFA     = 1'b1;
        RW_RAM  = rw;
        ADDRESS = addr;
        DATA_IN = din;
        TYPE    = typ;
        @(posedge CLK);
        @(negedge CLK);
        check({tag, " mfc after accept"}, {31'h0, MFC}, 32'h0);
        RW_RAM  = ~rw;
        ADDRESS = ~addr;
        DATA_IN = ~din;
        TYPE    = ~typ;
        for (int i = 1; i < Lat; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check({tag, " mfc busy"}, {31'h0, MFC}, 32'h0);
        end
        @(posedge CLK);
        @(negedge CLK);
        check({tag, " mfc rise"}, {31'h0, MFC}, 32'h1);
        check({tag, " dout"}, DATA_OUT, exp_dout);
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check({tag, " mfc hold"}, {31'h0, MFC}, 32'h1);
            check({tag, " dout hold"}, DATA_OUT, exp_dout);
        end
        MFA = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check({tag, " mfc release"}, {31'h0, MFC}, 32'h0);
        last_dout = exp_dout;
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] din,
                      input logic [1:0] typ);
        access(tag, 1'b0, addr, din, typ, last_dout, 0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [1:0] typ,
                      input logic [31:0] exp);
        access(tag, 1'b1, addr, 32'h0, typ, exp, 0);
    endtask

    initial begin
        CLR       = 1'b1;
        MFA       = 1'b0;
        RW_RAM    = 1'b0;
        ADDRESS   = 32'h0;
        DATA_IN   = 32'h0;
        TYPE      = 2'b00;
        last_dout = 32'h0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("reset mfc", {31'h0, MFC}, 32'h0);
        check("reset dout", DATA_OUT, 32'h0);
        CLR = 1'b0;
        @(negedge CLK);

        // Basic word write/read
        wr("wr 10", 32'h10, 32'hDEADBEEF, 2'b10);
        rd("rd 10", 32'h10, 2'b10, 32'hDEADBEEF);

        // Big-endian byte and halfword
        wr("wr 20", 32'h20, 32'h11223344, 2'b10);
        rd("rd b21", 32'h21, 2'b00, 32'h00000022);
        rd("rd h23", 32'h23, 2'b01, 32'h00003344);
        rd("rd h20", 32'h20, 2'b01, 32'h00001122);
        wr("wr b23", 32'h23, 32'hFFFFFFAA, 2'b00);
        rd("rd w20", 32'h20, 2'b10, 32'h112233AA);
        wr("wr h20", 32'h21, 32'h0000BEEF, 2'b01);
        rd("rd t3 22", 32'h22, 2'b11, 32'hBEEF33AA);

        // Abort in BUSY
        wr("wr 30", 32'h30, 32'h0BADF00D, 2'b10);
        MFA     = 1'b1;
        RW_RAM  = 1'b0;
        ADDRESS = 32'h30;
        DATA_IN = 32'h55555555;
        TYPE    = 2'b10;
        @(posedge CLK);
        @(negedge CLK);
        check("abort mfc accept", {31'h0, MFC}, 32'h0);
        MFA = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check("abort mfc", {31'h0, MFC}, 32'h0);
        end
        check("abort dout", DATA_OUT, last_dout);
        rd("rd 30 after abort", 32'h30, 2'b10, 32'h0BADF00D);

        // Hold for 5 edges, then back-to-back request after release
        access("hold rd 10", 1'b1, 32'h10, 32'h0, 2'b10, 32'hDEADBEEF, 5);
        rd("rd after hold", 32'h20, 2'b10, 32'hBEEF33AA);

        // Reset mid-BUSY; MFA stays high through reset and must not be accepted then
        wr("wr 40", 32'h40, 32'h12345678, 2'b10);
        MFA     = 1'b1;
        RW_RAM  = 1'b0;
        ADDRESS = 32'h40;
        DATA_IN = 32'hA5A5A5A5;
        TYPE    = 2'b10;
        @(posedge CLK);
        @(negedge CLK);
        CLR = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("clr mfc", {31'h0, MFC}, 32'h0);
        check("clr dout", DATA_OUT, 32'h0);
        CLR       = 1'b0;
        last_dout = 32'h0;
        rd("rd 40 after clr", 32'h40, 2'b10, 32'h12345678);
        rd("rd 10 after clr", 32'h10, 2'b10, 32'hDEADBEEF);

        // Wrap-around and top-of-storage word
        wr("wr 204", 32'h00000204, 32'hCAFEF00D, 2'b10);
        rd("rd 004", 32'h004, 2'b10, 32'hCAFEF00D);
        wr("wr 1fe", 32'h1FE, 32'h01020304, 2'b10);
        rd("rd 3fc", 32'h3FC, 2'b10, 32'h01020304);
        rd("rd b1ff", 32'h1FF, 2'b00, 32'h00000004);
        rd("rd h1fd", 32'h1FD, 2'b01, 32'h00000102);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
